// File: rtl/glm_load.sv
// glm_load: fetches a block of host cache lines over CCI-P c0 into one BRAM channel.
// Responses may return in any order; each line is placed in BRAM by its mdata tag.
package glm_ccip_pkg;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef enum logic [1:0] {
        eVC_VA  = 2'h0,
        eVC_VL0 = 2'h1,
        eVC_VH0 = 2'h2,
        eVC_VH1 = 2'h3
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'h0,
        eCL_LEN_2 = 2'h1,
        eCL_LEN_4 = 2'h3
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;
endpackage

module glm_load
    import glm_ccip_pkg::*;
#(
    parameter int NUM_LOAD_CHANNELS = 2,
    parameter int BRAM_ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         op_start,
    output logic                         op_done,
    input  logic [31:0]                  regs [7],
    input  t_ccip_clAddr                 in_addr,
    input  t_ccip_clAddr                 out_addr,
    input  logic                         c0TxAlmFull,
    input  t_if_ccip_c0_Rx               cp2af_sRx_c0,
    output t_if_ccip_c0_Tx               af2cp_sTx_c0,
    output logic [NUM_LOAD_CHANNELS-1:0] bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_waddr,
    output logic [511:0]                 bram_wdata
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREPROCESS,
        S_READ,
        S_DONE
    } t_state;

    t_state                       r_state;
    t_state                       w_next;
    logic [31:0]                  r_offset [3];
    t_ccip_clAddr                 r_base;
    logic [15:0]                  r_length;
    logic [15:0]                  r_num_req;
    logic [15:0]                  r_num_rsp;
    logic [3:0]                   r_channel;
    logic [BRAM_ADDR_WIDTH-1:0]   r_bram_base;
    logic [1:0]                   r_idx;
    logic [31:0]                  w_offset;
    logic                         w_req;
    logic                         w_rsp;
    logic                         w_last;
    logic [NUM_LOAD_CHANNELS-1:0] w_we_mask;
    logic                         w_unused;

    assign w_req  = (r_state == S_READ) && !c0TxAlmFull
                    && (r_num_req < r_length);
    assign w_rsp  = (r_state == S_READ) && cp2af_sRx_c0.rspValid
                    && (cp2af_sRx_c0.hdr.resp_type == eRSP_RDLINE);
    assign w_last = w_rsp && (r_num_rsp == r_length - 16'd1);

    always_comb begin
        w_offset = r_offset[2];
        case (r_idx)
            2'd0:    w_offset = r_offset[0];
            2'd1:    w_offset = r_offset[1];
            default: w_offset = r_offset[2];
        endcase
    end

    // Out-of-range channel selects nothing, but the load still completes.
    always_comb begin
        w_we_mask = '0;
        for (int i = 0; i < NUM_LOAD_CHANNELS; i++) begin
            if (r_channel == 4'(i)) w_we_mask[i] = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (op_start) begin
                    w_next = (regs[4][15:0] == 16'd0) ? S_DONE : S_PREPROCESS;
                end
            end
            S_PREPROCESS: if (r_idx == 2'd2) w_next = S_READ;
            S_READ:       if (w_last) w_next = S_DONE;
            S_DONE:       w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        af2cp_sTx_c0 <= '0;
        op_done      <= 1'b0;
        bram_we      <= '0;
        if (reset) begin
            r_num_req <= '0;
            r_num_rsp <= '0;
            r_idx     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        r_offset[0] <= regs[0];
                        r_offset[1] <= regs[1];
                        r_offset[2] <= regs[2];
                        r_base      <= (regs[3][31] ? in_addr : out_addr)
                                       + {11'd0, regs[3][30:0]};
                        r_length    <= regs[4][15:0];
                        r_channel   <= regs[5][3:0];
                        r_bram_base <= regs[6][BRAM_ADDR_WIDTH-1:0];
                        r_num_req   <= '0;
                        r_num_rsp   <= '0;
                        r_idx       <= '0;
                    end
                end
                S_PREPROCESS: begin
                    r_base <= r_base + {10'd0, w_offset};
                    r_idx  <= r_idx + 2'd1;
                end
                S_READ: begin
                    if (w_req) begin
                        af2cp_sTx_c0.valid        <= 1'b1;
                        af2cp_sTx_c0.hdr.address  <= r_base + {26'd0, r_num_req};
                        af2cp_sTx_c0.hdr.mdata    <= r_num_req;
                        af2cp_sTx_c0.hdr.req_type <= eREQ_RDLINE_I;
                        af2cp_sTx_c0.hdr.vc_sel   <= eVC_VA;
                        af2cp_sTx_c0.hdr.cl_len   <= eCL_LEN_1;
                        r_num_req                 <= r_num_req + 16'd1;
                    end
                    if (w_rsp) begin
                        bram_we    <= w_we_mask;
                        bram_waddr <= r_bram_base
                            + cp2af_sRx_c0.hdr.mdata[BRAM_ADDR_WIDTH-1:0];
                        bram_wdata <= cp2af_sRx_c0.data;
                        r_num_rsp  <= r_num_rsp + 16'd1;
                    end
                end
                S_DONE:  op_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign w_unused = &{1'b0, cp2af_sRx_c0.mmioRdValid,
                        cp2af_sRx_c0.mmioWrValid,
                        cp2af_sRx_c0.hdr.vc_used, cp2af_sRx_c0.hdr.rsvd1,
                        cp2af_sRx_c0.hdr.hit_miss, cp2af_sRx_c0.hdr.rsvd0,
                        cp2af_sRx_c0.hdr.cl_num,
                        cp2af_sRx_c0.hdr.mdata[15:BRAM_ADDR_WIDTH],
                        regs[4][31:16], regs[5][31:4],
                        regs[6][31:BRAM_ADDR_WIDTH]};
endmodule

// File: tb/tb_glm_load.sv
// tb_glm_load: randomized bench for glm_load with a host-memory model.
// Expected requests and BRAM writes are queued at stimulus time and checked by a monitor.
`timescale 1ns/1ps
module tb_glm_load;
    import glm_ccip_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_start;
    logic           op_done;
    logic [31:0]    regs [7];
    t_ccip_clAddr   in_addr;
    t_ccip_clAddr   out_addr;
    logic           c0TxAlmFull;
    t_if_ccip_c0_Rx rx;
    t_if_ccip_c0_Tx tx;
    logic [NCH-1:0] bram_we;
    logic [AW-1:0]  bram_waddr;
    logic [511:0]   bram_wdata;

    glm_load #(.NUM_LOAD_CHANNELS(NCH), .BRAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done),
        .regs(regs), .in_addr(in_addr), .out_addr(out_addr),
        .c0TxAlmFull(c0TxAlmFull), .cp2af_sRx_c0(rx), .af2cp_sTx_c0(tx),
        .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0] addr;
        logic [15:0] mdata;
    } req_t;

    typedef struct {
        logic [NCH-1:0] we;
        logic [AW-1:0]  waddr;
        logic [511:0]   data;
    } wr_t;

    req_t        exp_req[$];
    wr_t         exp_wr[$];
    int          issued[$];
    int          ord[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_req_cyc = -1;
    logic        alm_prev = 1'b0;
    logic [31:0] salt;
    req_t        me;
    wr_t         mw;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mem_line(input logic [41:0] a);
        logic [511:0] d;
        for (int i = 0; i < 16; i++)
            d[i*32 +: 32] = (a[31:0] * (i + 1)) ^ 32'h9E37_79B9 ^ salt;
        return d;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        alm_prev <= c0TxAlmFull;
    end

    always @(negedge clk) begin
        if (tx.valid) begin
            chk("req_under_almfull", 512'(alm_prev), 512'(0));
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (exp_req.size() == 0) begin
                fail("req_unexpected");
            end else begin
                me = exp_req.pop_front();
                chk("req_addr", 512'(tx.hdr.address), 512'(me.addr));
                chk("req_mdata", 512'(tx.hdr.mdata), 512'(me.mdata));
                chk("req_kind",
                    512'({tx.hdr.vc_sel, tx.hdr.cl_len, tx.hdr.req_type}),
                    512'({eVC_VA, eCL_LEN_1, eREQ_RDLINE_I}));
                issued.push_back(int'(tx.hdr.mdata));
            end
        end
        if (bram_we != '0) begin
            if (exp_wr.size() == 0) begin
                fail("bram_we_unexpected");
            end else begin
                mw = exp_wr.pop_front();
                chk("bram_we", 512'(bram_we), 512'(mw.we));
                chk("bram_waddr", 512'(bram_waddr), 512'(mw.waddr));
                chk("bram_wdata", bram_wdata, mw.data);
            end
        end
        if (op_done) done_cnt++;
    end

    task automatic run_op(input int len, input int ch, input int bb,
                          input bit sel_in, input logic [30:0] off,
                          input logic [31:0] o0, input logic [31:0] o1,
                          input logic [31:0] o2, input bit ordered,
                          input int alm_from, input int alm_n,
                          input bit mmio, input int rst_after);
        logic [41:0] base;
        int sent;
        int n;
        int k;
        int m;
        int start_done;
        int start_cyc;
        bit sent_f [int];
        sent = 0;
        n = 0;
        base = (sel_in ? in_addr : out_addr) + 42'(off)
               + 42'(o0) + 42'(o1) + 42'(o2);
        regs[0] = o0;
        regs[1] = o1;
        regs[2] = o2;
        regs[3] = {sel_in, off};
        regs[4] = {16'hBEEF, 16'(len)};
        regs[5] = {28'($urandom), 4'(ch)};
        regs[6] = {22'($urandom), 10'(bb)};
        for (int i = 0; i < len; i++)
            exp_req.push_back('{addr: base + 42'(i), mdata: 16'(i)});
        issued.delete();
        first_req_cyc = -1;
        start_done = done_cnt;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        start_cyc = cyc;
        while (sent < len && n < 3000) begin
            if (rst_after >= 0 && sent == rst_after) break;
            n++;
            c0TxAlmFull = (n >= alm_from && n < alm_from + alm_n);
            rx = '0;
            k = -1;
            if (issued.size() > 0) begin
                if (ordered) begin
                    for (int j = 0; j < issued.size(); j++)
                        if (issued[j] == ord[sent]) k = j;
                end else if ($urandom_range(0, 2) != 0) begin
                    k = int'($urandom_range(0, issued.size() - 1));
                end
            end
            if (k >= 0) begin
                m = issued[k];
                issued.delete(k);
                rx.rspValid = 1'b1;
                rx.hdr.resp_type = eRSP_RDLINE;
                rx.hdr.mdata = 16'(m);
                rx.data = mem_line(base + 42'(m));
                if (ch < NCH)
                    exp_wr.push_back('{we: NCH'(1 << ch),
                                       waddr: AW'(bb + m), data: rx.data});
                sent_f[m] = 1'b1;
                sent++;
            end else if (mmio && $urandom_range(0, 1) == 1) begin
                rx.hdr.mdata = 16'($urandom);
                rx.data = {16{$urandom}};
                if ($urandom_range(0, 1) == 1) begin
                    rx.rspValid = 1'b1;
                    rx.hdr.resp_type = eRSP_UMSG;
                end else begin
                    rx.mmioWrValid = 1'b1;
                end
            end
            tick();
        end
        rx = '0;
        c0TxAlmFull = 1'b0;
        if (n >= 3000) fail("rsp_timeout");
        if (rst_after >= 0) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            @(negedge clk);
            chk("rst_valid", 512'(tx.valid), 512'(0));
            chk("rst_hdr", 512'(tx.hdr), 512'(0));
            chk("rst_we", 512'(bram_we), 512'(0));
            chk("rst_done", 512'(op_done), 512'(0));
            chk("rst_pending_wr", 512'(exp_wr.size()), 512'(0));
            exp_req.delete();
            issued.delete();
            tick();
            for (int i = 0; i < len; i++) begin
                if (!sent_f.exists(i)) begin
                    rx = '0;
                    rx.rspValid = 1'b1;
                    rx.hdr.resp_type = eRSP_RDLINE;
                    rx.hdr.mdata = 16'(i);
                    rx.data = mem_line(base + 42'(i));
                    tick();
                end
            end
            rx = '0;
            repeat (4) tick();
            chk("rst_no_done", 512'(done_cnt - start_done), 512'(0));
            return;
        end
        k = -1;
        for (int j = 0; j < 20 && k < 0; j++) begin
            @(negedge clk);
            if (op_done) k = j;
        end
        if (k < 0) fail("done_timeout");
        else chk("done_latency", 512'(k), 512'(1));
        repeat (2) tick();
        chk("done_count", 512'(done_cnt - start_done), 512'(1));
        chk("req_left", 512'(exp_req.size()), 512'(0));
        chk("wr_left", 512'(exp_wr.size()), 512'(0));
        if (alm_n == 0 && len > 0)
            chk("first_req_lat", 512'(first_req_cyc - start_cyc), 512'(4));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        salt = $urandom;
        reset = 1'b1;
        op_start = 1'b0;
        c0TxAlmFull = 1'b0;
        rx = '0;
        for (int i = 0; i < 7; i++) regs[i] = '0;
        in_addr = '0;
        out_addr = '0;
        tick();
        tick();
        @(negedge clk);
        chk("reset_valid", 512'(tx.valid), 512'(0));
        chk("reset_hdr", 512'(tx.hdr), 512'(0));
        chk("reset_we", 512'(bram_we), 512'(0));
        chk("reset_done", 512'(op_done), 512'(0));
        tick();
        reset = 1'b0;
        tick();

        run_op(0, 0, 0, 1'b0, 31'h10, 1, 2, 3, 1'b0, 0, 0, 1'b0, -1);

        out_addr = 42'h1000;
        ord = '{0, 1, 2, 3};
        run_op(4, 0, 8, 1'b0, 31'h10, 1, 2, 3, 1'b1, 0, 0, 1'b0, -1);
        ord = '{3, 1, 0, 2};
        run_op(4, 0, 8, 1'b0, 31'h10, 1, 2, 3, 1'b1, 0, 0, 1'b0, -1);

        in_addr = 42'h2000;
        ord = '{0, 1, 2, 3};
        run_op(4, 1, 8, 1'b1, 31'h4, 1, 2, 3, 1'b1, 0, 0, 1'b0, -1);

        run_op(8, 0, 100, 1'b0, 31'h40, 5, 6, 7, 1'b0, 5, 5, 1'b1, -1);

        run_op(6, 1, 200, 1'b1, 31'h80, 2, 2, 2, 1'b0, 0, 0, 1'b0, 2);
        run_op(5, 0, 300, 1'b0, 31'h99, 3, 0, 9, 1'b0, 0, 0, 1'b1, -1);

        run_op(6, 0, 1021, 1'b1, 31'h7, 0, 0, 0, 1'b0, 0, 0, 1'b0, -1);
        run_op(3, 3, 50, 1'b0, 31'h3, 1, 1, 1, 1'b0, 0, 0, 1'b1, -1);

        for (int t = 0; t < 8; t++) begin
            in_addr = 42'($urandom) << 8;
            out_addr = 42'($urandom) << 8;
            run_op(int'($urandom_range(1, 16)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 1023)), 1'($urandom),
                   31'($urandom), $urandom, $urandom, $urandom, 1'b0,
                   int'($urandom_range(4, 10)),
                   int'($urandom_range(0, 1)) * int'($urandom_range(1, 6)),
                   1'($urandom), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
